// File: rtl/v_pipe_update_mc.sv
// ============================================================================
// Module   : v_pipe_update_mc
// Brief    : 4-stage read-modify-write pipe maintaining per-product sorted
//            key/size lists in an external synchronous state RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module v_pipe_update_mc #(
  parameter int ID_W      = 4,
  parameter int KEY_W     = 16,
  parameter int SIZE_W    = 16,
  parameter int N         = 4,
  parameter bit SORT_DESC = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_upd_vld,
  input  logic [ID_W-1:0]                i_upd_prod_id,
  input  logic [2:0]                     i_upd_cmd,
  input  logic [KEY_W-1:0]               i_upd_key,
  input  logic [SIZE_W-1:0]              i_upd_size,
  output logic                           o_state_ren,
  output logic [ID_W-1:0]                o_state_raddr,
  input  logic [N*(1+KEY_W+SIZE_W)-1:0]  i_state_rdata,
  output logic                           o_state_wen_r,
  output logic [ID_W-1:0]                o_state_waddr_r,
  output logic [N*(1+KEY_W+SIZE_W)-1:0]  o_state_wdata_r,
  output logic                           o_lv0_vld_r,
  output logic [ID_W-1:0]                o_lv0_prod_id_r,
  output logic [KEY_W-1:0]               o_lv0_key_r,
  output logic [SIZE_W-1:0]              o_lv0_size_r,
  output logic                           o_err_vld_r,
  output logic [1:0]                     o_err_code_r,
  output logic                           o_s1_upd_vld_r,
  output logic [ID_W-1:0]                o_s1_upd_prod_id_r,
  output logic                           o_s2_upd_vld_r,
  output logic [ID_W-1:0]                o_s2_upd_prod_id_r,
  output logic                           o_s3_upd_vld_r,
  output logic [ID_W-1:0]                o_s3_upd_prod_id_r,
  output logic                           o_s4_upd_vld_r,
  output logic [ID_W-1:0]                o_s4_upd_prod_id_r
);

  localparam int c_EW  = 1 + KEY_W + SIZE_W;
  localparam int c_LW  = N * c_EW;
  localparam int c_VB  = c_EW - 1;
  localparam int c_KHI = KEY_W + SIZE_W - 1;
  localparam int c_CW  = $clog2(N + 1);

  localparam logic [2:0] c_CMD_NOP     = 3'd0;
  localparam logic [2:0] c_CMD_CLEAR   = 3'd1;
  localparam logic [2:0] c_CMD_ADD     = 3'd2;
  localparam logic [2:0] c_CMD_DEL     = 3'd3;
  localparam logic [2:0] c_CMD_REPLACE = 3'd4;

  localparam logic [1:0] c_ERR_FULL    = 2'd1;
  localparam logic [1:0] c_ERR_DELMISS = 2'd2;
  localparam logic [1:0] c_ERR_ILLEGAL = 2'd3;

  logic              r_s1_vld, r_s2_vld, r_s3_vld, r_s4_vld;
  logic [ID_W-1:0]   r_s1_prod, r_s2_prod, r_s3_prod, r_s4_prod;
  logic [2:0]        r_s1_cmd, r_s2_cmd, r_s3_cmd;
  logic [KEY_W-1:0]  r_s1_key, r_s2_key, r_s3_key;
  logic [SIZE_W-1:0] r_s1_size, r_s2_size, r_s3_size;
  logic [c_LW-1:0]   r_s3_state;

  logic              r_h1_vld, r_h2_vld;
  logic [ID_W-1:0]   r_h1_addr, r_h2_addr;
  logic [c_LW-1:0]   r_h1_data, r_h2_data;

  logic [c_LW-1:0]   w_src;
  logic [c_LW-1:0]   w_wdata;
  logic [c_EW-1:0]   w_cur [N];
  logic [c_EW-1:0]   w_nxt [N];
  logic [c_EW-1:0]   w_up  [N];
  logic [c_EW-1:0]   w_dn  [N];
  logic [c_EW-1:0]   w_new_ent;
  logic              w_hit;
  logic [c_CW-1:0]   w_midx, w_pos, w_cnt;
  logic [SIZE_W-1:0] w_msize, w_newsz;
  logic [SIZE_W:0]   w_sum;
  logic              w_ins, w_rem, w_setsz, w_clr;
  logic              w_do_wr, w_err, w_lv0;
  logic [1:0]        w_ecode;

  assign o_state_ren        = r_s1_vld;
  assign o_state_raddr      = r_s1_prod;
  assign o_s1_upd_vld_r     = r_s1_vld;
  assign o_s1_upd_prod_id_r = r_s1_prod;
  assign o_s2_upd_vld_r     = r_s2_vld;
  assign o_s2_upd_prod_id_r = r_s2_prod;
  assign o_s3_upd_vld_r     = r_s3_vld;
  assign o_s3_upd_prod_id_r = r_s3_prod;
  assign o_s4_upd_vld_r     = r_s4_vld;
  assign o_s4_upd_prod_id_r = r_s4_prod;

  // Control path and output registers: async reset kills in-flight ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld        <= 1'b0;
      r_s2_vld        <= 1'b0;
      r_s3_vld        <= 1'b0;
      r_s4_vld        <= 1'b0;
      r_s1_prod       <= '0;
      r_s2_prod       <= '0;
      r_s3_prod       <= '0;
      r_s4_prod       <= '0;
      r_h1_vld        <= 1'b0;
      r_h2_vld        <= 1'b0;
      o_state_wen_r   <= 1'b0;
      o_state_waddr_r <= '0;
      o_state_wdata_r <= '0;
      o_lv0_vld_r     <= 1'b0;
      o_lv0_prod_id_r <= '0;
      o_lv0_key_r     <= '0;
      o_lv0_size_r    <= '0;
      o_err_vld_r     <= 1'b0;
      o_err_code_r    <= '0;
    end else begin
      r_s1_vld <= i_upd_vld;
      r_s2_vld <= r_s1_vld;
      r_s3_vld <= r_s2_vld;
      r_s4_vld <= r_s3_vld;
      if (i_upd_vld) r_s1_prod <= i_upd_prod_id;
      if (r_s1_vld)  r_s2_prod <= r_s1_prod;
      if (r_s2_vld)  r_s3_prod <= r_s2_prod;
      if (r_s3_vld)  r_s4_prod <= r_s3_prod;
      o_state_wen_r <= r_s3_vld & w_do_wr;
      o_lv0_vld_r   <= r_s3_vld & w_lv0;
      o_err_vld_r   <= r_s3_vld & w_err;
      if (r_s3_vld) begin
        o_state_waddr_r <= r_s3_prod;
        o_state_wdata_r <= w_wdata;
        o_lv0_prod_id_r <= r_s3_prod;
        o_lv0_key_r     <= w_nxt[0][c_VB] ? w_nxt[0][c_KHI -: KEY_W] : '0;
        o_lv0_size_r    <= w_nxt[0][c_VB] ? w_nxt[0][SIZE_W-1:0] : '0;
        o_err_code_r    <= w_ecode;
      end
      r_h1_vld <= o_state_wen_r;
      r_h2_vld <= r_h1_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (i_upd_vld) begin
      r_s1_cmd  <= i_upd_cmd;
      r_s1_key  <= i_upd_key;
      r_s1_size <= i_upd_size;
    end
    if (r_s1_vld) begin
      r_s2_cmd  <= r_s1_cmd;
      r_s2_key  <= r_s1_key;
      r_s2_size <= r_s1_size;
    end
    if (r_s2_vld) begin
      r_s3_cmd   <= r_s2_cmd;
      r_s3_key   <= r_s2_key;
      r_s3_size  <= r_s2_size;
      r_s3_state <= i_state_rdata;
    end
    if (o_state_wen_r) begin
      r_h1_addr <= o_state_waddr_r;
      r_h1_data <= o_state_wdata_r;
    end
    if (r_h1_vld) begin
      r_h2_addr <= r_h1_addr;
      r_h2_data <= r_h1_data;
    end
  end

  // Writes issued in the three cycles after the S1 read are not yet in
  // rdata; take the newest one for this product.
  always_comb begin
    w_src = r_s3_state;
    if (o_state_wen_r && (o_state_waddr_r == r_s3_prod))
      w_src = o_state_wdata_r;
    else if (r_h1_vld && (r_h1_addr == r_s3_prod))
      w_src = r_h1_data;
    else if (r_h2_vld && (r_h2_addr == r_s3_prod))
      w_src = r_h2_data;
  end

  always_comb begin
    w_hit     = 1'b0;
    w_midx    = '0;
    w_pos     = '0;
    w_cnt     = '0;
    w_msize   = '0;
    w_newsz   = '0;
    w_ins     = 1'b0;
    w_rem     = 1'b0;
    w_setsz   = 1'b0;
    w_clr     = 1'b0;
    w_do_wr   = 1'b0;
    w_err     = 1'b0;
    w_ecode   = '0;
    w_new_ent = {1'b1, r_s3_key, r_s3_size};
    w_wdata   = '0;

    for (int i = 0; i < N; i++) begin
      w_cur[i] = w_src[i*c_EW +: c_EW];
    end
    for (int i = 0; i < N; i++) begin
      if (w_cur[i][c_VB]) begin
        w_cnt = w_cnt + c_CW'(1);
        if (w_cur[i][c_KHI -: KEY_W] == r_s3_key) begin
          w_hit   = 1'b1;
          w_midx  = c_CW'(i);
          w_msize = w_cur[i][SIZE_W-1:0];
        end
        // Insert position = number of valid entries ranking ahead of the key
        if (SORT_DESC ? (w_cur[i][c_KHI -: KEY_W] > r_s3_key)
                      : (w_cur[i][c_KHI -: KEY_W] < r_s3_key))
          w_pos = w_pos + c_CW'(1);
      end
    end

    w_dn[0]   = '0;
    w_up[N-1] = '0;
    for (int i = 1; i < N; i++) w_dn[i] = w_cur[i-1];
    for (int i = 0; i < N - 1; i++) w_up[i] = w_cur[i+1];

    w_sum = {1'b0, w_msize} + {1'b0, r_s3_size};

    case (r_s3_cmd)
      c_CMD_NOP: ;
      c_CMD_CLEAR: begin
        w_clr   = 1'b1;
        w_do_wr = 1'b1;
      end
      c_CMD_ADD, c_CMD_REPLACE: begin
        if (w_hit) begin
          w_do_wr = 1'b1;
          if (r_s3_cmd == c_CMD_ADD) begin
            w_setsz = 1'b1;
            w_newsz = w_sum[SIZE_W] ? '1 : w_sum[SIZE_W-1:0];
          end else if (r_s3_size == '0) begin
            w_rem = 1'b1;
          end else begin
            w_setsz = 1'b1;
            w_newsz = r_s3_size;
          end
        end else if ((w_cnt == c_CW'(N)) && (w_pos == c_CW'(N))) begin
          w_err   = 1'b1;
          w_ecode = c_ERR_FULL;
        end else begin
          w_ins   = 1'b1;
          w_do_wr = 1'b1;
          if (w_cnt == c_CW'(N)) begin
            w_err   = 1'b1;
            w_ecode = c_ERR_FULL;
          end
        end
      end
      c_CMD_DEL: begin
        if (w_hit) begin
          w_do_wr = 1'b1;
          if (w_msize <= r_s3_size) begin
            w_rem = 1'b1;
          end else begin
            w_setsz = 1'b1;
            w_newsz = w_msize - r_s3_size;
          end
        end else begin
          w_err   = 1'b1;
          w_ecode = c_ERR_DELMISS;
        end
      end
      default: begin
        w_err   = 1'b1;
        w_ecode = c_ERR_ILLEGAL;
      end
    endcase

    for (int i = 0; i < N; i++) begin
      w_nxt[i] = w_cur[i];
      if (w_clr) begin
        w_nxt[i] = '0;
      end else if (w_ins) begin
        if (c_CW'(i) == w_pos)     w_nxt[i] = w_new_ent;
        else if (c_CW'(i) > w_pos) w_nxt[i] = w_dn[i];
      end else if (w_rem) begin
        if (c_CW'(i) >= w_midx)    w_nxt[i] = w_up[i];
      end else if (w_setsz && (c_CW'(i) == w_midx)) begin
        w_nxt[i][SIZE_W-1:0] = w_newsz;
      end
      w_wdata[i*c_EW +: c_EW] = w_nxt[i];
    end

    w_lv0 = w_do_wr && (w_nxt[0] != w_cur[0]);
  end

endmodule

`default_nettype wire

// File: tb/tb_v_pipe_update_mc.sv
// ============================================================================
// Module   : tb_v_pipe_update_mc
// Brief    : Scoreboard bench for v_pipe_update_mc with a read-old-data RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_v_pipe_update_mc;

  localparam int ID_W = 4;
  localparam int KEY_W = 16;
  localparam int SIZE_W = 16;
  localparam int N = 4;
  localparam int LW = N * (1 + KEY_W + SIZE_W);
  localparam logic [32:0] Z = '0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_upd_vld = 1'b0;
  logic [ID_W-1:0]   i_upd_prod_id = '0;
  logic [2:0]        i_upd_cmd = '0;
  logic [KEY_W-1:0]  i_upd_key = '0;
  logic [SIZE_W-1:0] i_upd_size = '0;
  logic              o_state_ren;
  logic [ID_W-1:0]   o_state_raddr;
  logic [LW-1:0]     i_state_rdata = '0;
  logic              o_state_wen_r;
  logic [ID_W-1:0]   o_state_waddr_r;
  logic [LW-1:0]     o_state_wdata_r;
  logic              o_lv0_vld_r;
  logic [ID_W-1:0]   o_lv0_prod_id_r;
  logic [KEY_W-1:0]  o_lv0_key_r;
  logic [SIZE_W-1:0] o_lv0_size_r;
  logic              o_err_vld_r;
  logic [1:0]        o_err_code_r;
  logic              o_s1_upd_vld_r, o_s2_upd_vld_r, o_s3_upd_vld_r, o_s4_upd_vld_r;
  logic [ID_W-1:0]   o_s1_upd_prod_id_r, o_s2_upd_prod_id_r;
  logic [ID_W-1:0]   o_s3_upd_prod_id_r, o_s4_upd_prod_id_r;

  typedef struct packed {
    logic          wen;
    logic [3:0]    prod;
    logic [LW-1:0] wdata;
    logic          lv0;
    logic [15:0]   lkey;
    logic [15:0]   lsize;
    logic          err;
    logic [1:0]    ecode;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [LW-1:0] mem [16];

  v_pipe_update_mc #(
    .ID_W(ID_W), .KEY_W(KEY_W), .SIZE_W(SIZE_W), .N(N), .SORT_DESC(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_upd_vld(i_upd_vld), .i_upd_prod_id(i_upd_prod_id), .i_upd_cmd(i_upd_cmd),
    .i_upd_key(i_upd_key), .i_upd_size(i_upd_size),
    .o_state_ren(o_state_ren), .o_state_raddr(o_state_raddr),
    .i_state_rdata(i_state_rdata),
    .o_state_wen_r(o_state_wen_r), .o_state_waddr_r(o_state_waddr_r),
    .o_state_wdata_r(o_state_wdata_r),
    .o_lv0_vld_r(o_lv0_vld_r), .o_lv0_prod_id_r(o_lv0_prod_id_r),
    .o_lv0_key_r(o_lv0_key_r), .o_lv0_size_r(o_lv0_size_r),
    .o_err_vld_r(o_err_vld_r), .o_err_code_r(o_err_code_r),
    .o_s1_upd_vld_r(o_s1_upd_vld_r), .o_s1_upd_prod_id_r(o_s1_upd_prod_id_r),
    .o_s2_upd_vld_r(o_s2_upd_vld_r), .o_s2_upd_prod_id_r(o_s2_upd_prod_id_r),
    .o_s3_upd_vld_r(o_s3_upd_vld_r), .o_s3_upd_prod_id_r(o_s3_upd_prod_id_r),
    .o_s4_upd_vld_r(o_s4_upd_vld_r), .o_s4_upd_prod_id_r(o_s4_upd_prod_id_r)
  );

  always #5 clk = ~clk;

  // Synchronous state RAM, read-old-data on collision
  always @(posedge clk) begin
    if (o_state_ren) i_state_rdata <= mem[o_state_raddr];
    if (o_state_wen_r) mem[o_state_waddr_r] <= o_state_wdata_r;
  end

  function automatic logic [32:0] pk(input int k, input int s);
    return {1'b1, k[15:0], s[15:0]};
  endfunction

  function automatic logic [LW-1:0] lst(input logic [32:0] e0, input logic [32:0] e1,
                                        input logic [32:0] e2, input logic [32:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic exp_t ex(input int w, input int p, input logic [LW-1:0] d,
                              input int l, input int lk, input int ls,
                              input int er, input int ec);
    exp_t e;
    e.wen = w[0]; e.prod = p[3:0]; e.wdata = d;
    e.lv0 = l[0]; e.lkey = lk[15:0]; e.lsize = ls[15:0];
    e.err = er[0]; e.ecode = ec[1:0];
    return e;
  endfunction

  // Scoreboard: every op leaving S4 is compared against its queued result
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o_s4_upd_vld_r) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_op: got s4 prod=%0d, required none", o_s4_upd_prod_id_r);
      end else begin
        e = sb.pop_front();
        if (o_s4_upd_prod_id_r !== e.prod) begin
          n_fail++;
          $display("FAIL s4_prod: got %0d required %0d", o_s4_upd_prod_id_r, e.prod);
        end
        n_checks++;
        if (o_state_wen_r !== e.wen) begin
          n_fail++;
          $display("FAIL wen prod=%0d: got %b required %b", e.prod, o_state_wen_r, e.wen);
        end
        if (e.wen) begin
          n_checks++;
          if (o_state_waddr_r !== e.prod || o_state_wdata_r !== e.wdata) begin
            n_fail++;
            $display("FAIL wdata prod=%0d: got addr=%0d data=%h required addr=%0d data=%h",
                     e.prod, o_state_waddr_r, o_state_wdata_r, e.prod, e.wdata);
          end
        end
        n_checks++;
        if (o_lv0_vld_r !== e.lv0) begin
          n_fail++;
          $display("FAIL lv0_vld prod=%0d: got %b required %b", e.prod, o_lv0_vld_r, e.lv0);
        end
        if (e.lv0) begin
          n_checks++;
          if (o_lv0_prod_id_r !== e.prod || o_lv0_key_r !== e.lkey || o_lv0_size_r !== e.lsize) begin
            n_fail++;
            $display("FAIL lv0_data: got prod=%0d key=%0d size=%0d required prod=%0d key=%0d size=%0d",
                     o_lv0_prod_id_r, o_lv0_key_r, o_lv0_size_r, e.prod, e.lkey, e.lsize);
          end
        end
        n_checks++;
        if (o_err_vld_r !== e.err) begin
          n_fail++;
          $display("FAIL err_vld prod=%0d: got %b required %b", e.prod, o_err_vld_r, e.err);
        end
        if (e.err) begin
          n_checks++;
          if (o_err_code_r !== e.ecode) begin
            n_fail++;
            $display("FAIL err_code prod=%0d: got %0d required %0d", e.prod, o_err_code_r, e.ecode);
          end
        end
      end
    end
  end

  task automatic send(input int p, input int c, input int k, input int s,
                      input bit push, input exp_t e);
    if (push) sb.push_back(e);
    i_upd_vld     = 1'b1;
    i_upd_prod_id = p[3:0];
    i_upd_cmd     = c[2:0];
    i_upd_key     = k[15:0];
    i_upd_size    = s[15:0];
    @(posedge clk); #1;
    i_upd_vld = 1'b0;
    i_upd_cmd = 3'd0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending results, required 0", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({o_state_ren, o_state_wen_r, o_lv0_vld_r, o_err_vld_r,
         o_s1_upd_vld_r, o_s2_upd_vld_r, o_s3_upd_vld_r, o_s4_upd_vld_r} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ren/wen/lv0/err/s1-s4 vld=%b required 00000000",
               {o_state_ren, o_state_wen_r, o_lv0_vld_r, o_err_vld_r,
                o_s1_upd_vld_r, o_s2_upd_vld_r, o_s3_upd_vld_r, o_s4_upd_vld_r});
    end
    n_checks++;
    if (o_state_wdata_r !== '0 || o_lv0_key_r !== '0 || o_lv0_size_r !== '0 || o_err_code_r !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got wdata=%h key=%0d size=%0d code=%0d required all 0",
               o_state_wdata_r, o_lv0_key_r, o_lv0_size_r, o_err_code_r);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_basic();
    send(3, 2, 100, 5, 1, ex(1, 3, lst(pk(100, 5), Z, Z, Z), 1, 100, 5, 0, 0));
    n_checks++;
    if (o_state_ren !== 1'b1 || o_state_raddr !== 4'd3) begin
      n_fail++;
      $display("FAIL s1_read: got ren=%b raddr=%0d required ren=1 raddr=3", o_state_ren, o_state_raddr);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (o_state_wen_r !== 1'b0) begin
      n_fail++;
      $display("FAIL early_wen: got wen=%b in cycle 3 required 0", o_state_wen_r);
    end
    @(posedge clk); #1;
    n_checks++;
    if (o_state_wen_r !== 1'b1 || o_state_waddr_r !== 4'd3) begin
      n_fail++;
      $display("FAIL latency_wen: got wen=%b waddr=%0d in cycle 4 required wen=1 waddr=3",
               o_state_wen_r, o_state_waddr_r);
    end
    wait_drain();
    n_checks++;
    if (mem[3] !== lst(pk(100, 5), Z, Z, Z)) begin
      n_fail++;
      $display("FAIL ram_id3: got %h required %h", mem[3], lst(pk(100, 5), Z, Z, Z));
    end
  endtask

  task automatic test_sorted_insert();
    send(2, 2, 10, 1, 1, ex(1, 2, lst(pk(10, 1), Z, Z, Z), 1, 10, 1, 0, 0));
    send(2, 2, 30, 2, 1, ex(1, 2, lst(pk(30, 2), pk(10, 1), Z, Z), 1, 30, 2, 0, 0));
    send(2, 2, 20, 3, 1, ex(1, 2, lst(pk(30, 2), pk(20, 3), pk(10, 1), Z), 0, 0, 0, 0, 0));
    wait_drain();
  endtask

  task automatic test_full();
    mem[1] = lst(pk(40, 4), pk(30, 3), pk(20, 2), pk(10, 1));
    send(1, 2, 5, 7, 1, ex(0, 1, '0, 0, 0, 0, 1, 1));
    send(1, 2, 35, 9, 1, ex(1, 1, lst(pk(40, 4), pk(35, 9), pk(30, 3), pk(20, 2)), 0, 0, 0, 1, 1));
    send(1, 2, 50, 6, 1, ex(1, 1, lst(pk(50, 6), pk(40, 4), pk(35, 9), pk(30, 3)), 1, 50, 6, 1, 1));
    wait_drain();
  endtask

  task automatic test_del();
    mem[0] = lst(pk(50, 8), Z, Z, Z);
    send(0, 3, 77, 1, 1, ex(0, 0, '0, 0, 0, 0, 1, 2));
    send(0, 3, 50, 3, 1, ex(1, 0, lst(pk(50, 5), Z, Z, Z), 1, 50, 5, 0, 0));
    send(0, 3, 50, 8, 1, ex(1, 0, '0, 1, 0, 0, 0, 0));
    wait_drain();
  endtask

  task automatic test_replace_clear();
    mem[5] = lst(pk(40, 4), pk(30, 30), pk(20, 2), Z);
    send(5, 3, 30, 30, 1, ex(1, 5, lst(pk(40, 4), pk(20, 2), Z, Z), 0, 0, 0, 0, 0));
    send(5, 4, 40, 0, 1, ex(1, 5, lst(pk(20, 2), Z, Z, Z), 1, 20, 2, 0, 0));
    send(5, 4, 20, 11, 1, ex(1, 5, lst(pk(20, 11), Z, Z, Z), 1, 20, 11, 0, 0));
    send(5, 4, 60, 2, 1, ex(1, 5, lst(pk(60, 2), pk(20, 11), Z, Z), 1, 60, 2, 0, 0));
    send(5, 1, 0, 0, 1, ex(1, 5, '0, 1, 0, 0, 0, 0));
    send(5, 1, 0, 0, 1, ex(1, 5, '0, 0, 0, 0, 0, 0));
    send(5, 0, 60, 2, 1, ex(0, 5, '0, 0, 0, 0, 0, 0));
    wait_drain();
  endtask

  task automatic test_back_to_back();
    mem[8] = lst(pk(9, 16'hFFFE), Z, Z, Z);
    for (int k = 1; k <= 4; k++)
      send(7, 2, 9, 1, 1, ex(1, 7, lst(pk(9, k), Z, Z, Z), 1, 9, k, 0, 0));
    send(7, 2, 9, 1, 1, ex(1, 7, lst(pk(9, 5), Z, Z, Z), 1, 9, 5, 0, 0));
    send(6, 2, 1, 1, 1, ex(1, 6, lst(pk(1, 1), Z, Z, Z), 1, 1, 1, 0, 0));
    send(7, 2, 9, 1, 1, ex(1, 7, lst(pk(9, 6), Z, Z, Z), 1, 9, 6, 0, 0));
    send(8, 2, 9, 16'hFFFF, 1, ex(1, 8, lst(pk(9, 16'hFFFF), Z, Z, Z), 1, 9, 16'hFFFF, 0, 0));
    send(8, 2, 9, 1, 1, ex(1, 8, lst(pk(9, 16'hFFFF), Z, Z, Z), 0, 0, 0, 0, 0));
    wait_drain();
    n_checks++;
    if (mem[7] !== lst(pk(9, 6), Z, Z, Z)) begin
      n_fail++;
      $display("FAIL ram_id7: got %h required %h", mem[7], lst(pk(9, 6), Z, Z, Z));
    end
  endtask

  task automatic test_reset_midop();
    bit saw_wen;
    send(4, 2, 1, 1, 0, '0);
    send(4, 2, 2, 1, 0, '0);
    @(posedge clk); #1;
    n_checks++;
    if (o_s2_upd_vld_r !== 1'b1 || o_s3_upd_vld_r !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_occupancy: got s2=%b s3=%b required 1 1", o_s2_upd_vld_r, o_s3_upd_vld_r);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_s1_upd_vld_r, o_s2_upd_vld_r, o_s3_upd_vld_r, o_s4_upd_vld_r, o_state_wen_r} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset: got s1-s4/wen=%b required 00000",
               {o_s1_upd_vld_r, o_s2_upd_vld_r, o_s3_upd_vld_r, o_s4_upd_vld_r, o_state_wen_r});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw_wen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_state_wen_r) saw_wen = 1'b1;
    end
    @(posedge clk); #1;
    n_checks++;
    if (saw_wen || mem[4] !== '0) begin
      n_fail++;
      $display("FAIL killed_write: got wen_seen=%b ram_id4=%h required 0 and 0", saw_wen, mem[4]);
    end
  endtask

  task automatic test_illegal();
    send(9, 6, 1, 1, 1, ex(0, 9, '0, 0, 0, 0, 1, 3));
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (o_err_vld_r !== 1'b0) begin
      n_fail++;
      $display("FAIL early_err: got err_vld=%b in cycle 3 required 0", o_err_vld_r);
    end
    @(posedge clk); #1;
    n_checks++;
    if (o_err_vld_r !== 1'b1 || o_err_code_r !== 2'd3 || o_state_wen_r !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_cycle4: got err=%b code=%0d wen=%b required 1 3 0",
               o_err_vld_r, o_err_code_r, o_state_wen_r);
    end
    send(9, 5, 1, 1, 1, ex(0, 9, '0, 0, 0, 0, 1, 3));
    send(9, 7, 1, 1, 1, ex(0, 9, '0, 0, 0, 0, 1, 3));
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_add_basic();
    test_sorted_insert();
    test_full();
    test_del();
    test_replace_clear();
    test_back_to_back();
    test_reset_midop();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
